// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// FSM encoding and default operand width.
package muldiv_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIXUP,
        S_DONE
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide
// step on {acc, sr}. Multiply shifts right; divide shifts left.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] sr_in,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] sr_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    assign sum     = {1'b0, acc_in} + (sr_in[0] ? {1'b0, operand} : '0);
    assign shifted = {acc_in, sr_in[WIDTH-1]};
    // The true difference is below the divisor whenever it is kept, so WIDTH bits suffice.
    assign diff    = shifted[WIDTH-1:0] - operand;
    assign fits    = (shifted >= {1'b0, operand});

    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        acc_out = acc_in;
        sr_out  = sr_in;
        if (is_div) begin
            acc_out = fits ? diff : shifted[WIDTH-1:0];
            sr_out  = {sr_in[WIDTH-2:0], fits};
        end else begin
            acc_out = sum[WIDTH:1];
            sr_out  = {sum[0], sr_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller owning the HI/LO pair.
// Works on magnitudes in RUN and applies signs in FIXUP.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH           = WIDTH_DEFAULT,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  op_e              op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int ITERS = WIDTH / STEPS_PER_CYCLE;
    localparam int CW    = $clog2(ITERS + 1);

    state_e           state, state_next;
    logic [CW-1:0]    count;
    logic             sign_a, sign_b, is_div, dbz;
    logic [WIDTH-1:0] acc, sr, operand;
    logic [WIDTH-1:0] chain_acc [STEPS_PER_CYCLE+1];
    logic [WIDTH-1:0] chain_sr  [STEPS_PER_CYCLE+1];

    logic             op_div, op_signed, accept, rt_zero;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign accept    = (state == S_IDLE) && start &&
                       (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
    assign rt_zero   = (rt_val == '0);
    assign mag_a     = (op_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign mag_b     = (op_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    assign chain_acc[0] = acc;
    assign chain_sr[0]  = sr;
    for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
        muldiv_step #(.WIDTH(WIDTH)) u_step (
            .is_div  (is_div),
            .acc_in  (chain_acc[i]),
            .sr_in   (chain_sr[i]),
            .operand (operand),
            .acc_out (chain_acc[i+1]),
            .sr_out  (chain_sr[i+1])
        );
    end

    assign product = {acc, sr};

    always_comb begin
        fix_hi = acc;
        fix_lo = sr;
        if (is_div) begin
            fix_lo = (sign_a ^ sign_b) ? -sr : sr;
            fix_hi = sign_a ? -acc : acc;
        end else begin
            {fix_hi, fix_lo} = (sign_a ^ sign_b) ? -product : product;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = (op_div && rt_zero) ? S_FIXUP : S_RUN;
            S_RUN:   if (count == CW'(ITERS - 1)) state_next = S_FIXUP;
            S_FIXUP: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            is_div  <= 1'b0;
            dbz     <= 1'b0;
            acc     <= '0;
            sr      <= '0;
            operand <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        count  <= '0;
                        is_div <= op_div;
                        acc    <= '0;
                        if (op_div && rt_zero) begin
                            // Divide by zero: FIXUP with cleared signs passes these straight to HI/LO.
                            dbz     <= 1'b1;
                            sign_a  <= 1'b0;
                            sign_b  <= 1'b0;
                            acc     <= rs_val;
                            sr      <= '1;
                            operand <= '0;
                        end else begin
                            dbz     <= 1'b0;
                            sign_a  <= op_signed & rs_val[WIDTH-1];
                            sign_b  <= op_signed & rt_val[WIDTH-1];
                            sr      <= op_div ? mag_a : mag_b;
                            operand <= op_div ? mag_b : mag_a;
                        end
                    end else if (start && op == OP_MTHI) begin
                        hi <= rs_val;
                    end else if (start && op == OP_MTLO) begin
                        lo <= rs_val;
                    end
                end
                S_RUN: begin
                    acc   <= chain_acc[STEPS_PER_CYCLE];
                    sr    <= chain_sr[STEPS_PER_CYCLE];
                    count <= count + 1'b1;
                end
                S_FIXUP: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign div_by_zero = done & dbz;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer; expectations come from
// plain 64-bit arithmetic on the MIPS HI/LO rules.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    op_e         op;
    logic [31:0] rs_val, rt_val;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(32), .STEPS_PER_CYCLE(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input op_e o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output bit z);
        logic [63:0] p;
        longint      sa, sb, q, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        z  = 1'b0;
        h  = '0;
        l  = '0;
        case (o)
            OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
            OP_MULT:  begin p = sa * sb;                 h = p[63:32]; l = p[31:0]; end
            OP_DIVU, OP_DIV: begin
                if (b == 32'd0) begin
                    z = 1'b1; h = a; l = '1;
                end else if (o == OP_DIVU) begin
                    l = a / b; h = a % b;
                end else begin
                    q = sa / sb; r = sa % sb;
                    l = q[31:0]; h = r[31:0];
                end
            end
            default: ;
        endcase
    endfunction

    task automatic run_op(input op_e o, input logic [31:0] a, input logic [31:0] b,
                          input int repulse_k, input bit start_in_done);
        logic [31:0] eh, el;
        bit          ez;
        bit          busy_ok;
        int          lat, done_at;
        model(o, a, b, eh, el, ez);
        lat     = ez ? 2 : 34;
        busy_ok = 1'b1;
        done_at = 0;
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                done_at = k;
                break;
            end
            if (k == 10) begin
                check("hold_hi", 64'(hi), 64'(model_hi));
                check("hold_lo", 64'(lo), 64'(model_lo));
            end
            start = 1'b0; rs_val = $urandom; rt_val = $urandom;
            if (k == repulse_k) begin start = 1'b1; op = o; rt_val = 32'd9; end
        end
        check("latency", 64'(done_at), 64'(lat));
        check("busy_span", 64'(busy_ok), 64'd1);
        check("hi", 64'(hi), 64'(eh));
        check("lo", 64'(lo), 64'(el));
        check("div_by_zero", 64'(div_by_zero), 64'(ez));
        model_hi = eh;
        model_lo = el;
        start = 1'b0;
        if (start_in_done) begin
            start = 1'b1; op = OP_MTHI; rs_val = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        start = 1'b0;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(done), 64'd0);
        check("idle_hi", 64'(hi), 64'(model_hi));
    endtask

    task automatic move_to(input op_e o, input logic [31:0] v);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = v;
        @(negedge clk);
        start = 1'b0;
        if (o == OP_MTHI) model_hi = v;
        else if (o == OP_MTLO) model_lo = v;
        check("mt_busy", 64'(busy), 64'd0);
        check("mt_done", 64'(done), 64'd0);
        check("mt_hi", 64'(hi), 64'(model_hi));
        check("mt_lo", 64'(lo), 64'(model_lo));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        op_e         o;
        reset = 1'b1; start = 1'b0; op = OP_MULT; rs_val = '0; rt_val = '0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1);
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5, 0, 1'b0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_op(OP_DIVU,  32'd100, 32'd7, 0, 1'b0);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(OP_DIVU,  32'h0000_1234, 32'd0, 0, 1'b1);
        run_op(OP_DIV,   32'hFFFF_FF00, 32'd0, 0, 1'b0);

        move_to(OP_MTHI, 32'hAAAA_5555);
        move_to(OP_MTLO, 32'h0F0F_0F0F);
        move_to(op_e'(3'd6), 32'h1111_2222);
        run_op(OP_MULTU, 32'd2, 32'd3, 5, 1'b0);

        // Abort a multiply with an asynchronous reset mid-run.
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; rs_val = 32'd77; rt_val = 32'd88;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        run_op(OP_MULTU, 32'd4, 32'd4, 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            o = op_e'($urandom_range(0, 3));
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                3:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            run_op(o, a, b, (n % 3 == 0) ? 7 : 0, (n % 4 == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for MIPS MULT/MULTU/DIV/DIVU and the HI/LO register pair.
- The main ALU has no divide and cannot hold a 64-bit product across instructions, so this block owns HI/LO.
- Iterates shift-add multiply or restoring divide, one step group per clock.
- Exposes busy/done for pipeline stall control; MTHI/MTLO write HI/LO directly.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- STEPS_PER_CYCLE, 1, iteration steps per clock; legal values 1, 2, 4; must divide WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request; sampled only in IDLE
- op  in  3  operation code from shared package
- rs_val  in  WIDTH  operand A (dividend or multiplicand)
- rt_val  in  WIDTH  operand B (divisor or multiplier)
- busy  out  1  high from the cycle after accepted MULT/DIV start through the done cycle
- done  out  1  one-cycle pulse; HI/LO are valid in this cycle
- div_by_zero  out  1  one-cycle pulse coincident with done on DIV/DIVU with rt_val==0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: all outputs are 0, and state is IDLE, counter 0, sign flags 0. Reset mid-operation aborts it; HI/LO become 0.
- States and transitions:
  - IDLE → RUN on an accepted start with op in {MULT, MULTU, DIV, DIVU}.
  - RUN → FIXUP when the counter reaches WIDTH/STEPS_PER_CYCLE.
  - FIXUP → DONE.
  - DONE → IDLE.
- Accept (edge T0), MULT/DIV:
  - Latch operands.
  - For signed ops, latch the operand signs and convert the operands to magnitude (unsigned negate; -2^31 stays 0x80000000).
- RUN: each cycle performs STEPS_PER_CYCLE iterations and increments the counter. Default latency is 32 RUN cycles.
- FIXUP:
  - Multiply: negate the 64-bit product if sign_a^sign_b.
  - Divide: negate the quotient if sign_a^sign_b; negate the remainder if sign_a.
- DONE:
  - HI/LO are written at the FIXUP→DONE edge.
  - done=1 for exactly one cycle.
  - Start-to-done is 34 cycles at default: start high at T0, done high in cycle T0+34.
- Result placement:
  - Multiply: HI=product[63:32], LO=product[31:0].
  - Divide: LO=quotient, HI=remainder.
- Divide by zero: skip RUN and go IDLE→FIXUP→DONE; done appears in cycle T0+2. Result is LO=all ones, HI=rs_val unmodified, div_by_zero=1 with done.
- Signed overflow (-2^31 / -1): LO=0x80000000, HI=0. No flag.
- MTHI/MTLO: accepted in IDLE only. HI or LO (respectively) takes rs_val at the next edge. State stays IDLE; busy and done are not asserted.
- start while busy (RUN/FIXUP/DONE): ignored with no queueing; operand changes have no effect.
- Undefined op codes: ignored.
- In DONE, start is ignored; a new start is accepted from IDLE on the following cycle.
- HI/LO hold their old values throughout RUN; partial results are never visible.

Decomposition:
- Package muldiv_pkg holds:
  - op codes: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5;
  - state encoding: IDLE, RUN, FIXUP, DONE;
  - the WIDTH default constant.
- Sub-module muldiv_step, combinational: one shift-add or restore-subtract iteration on {remainder/hi accumulator, quotient/lo shift register, operand}. It is instantiated STEPS_PER_CYCLE times in a chain.
- The sequencer holds the FSM, counter, sign flags and HI/LO.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → done at T0+34; HI=0xFFFFFFFE, LO=0x00000001; busy high cycles T0+1..T0+34.
- MULT rs=0xFFFFFFFD (-3), rt=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then DIV rs=0xFFFFFFF9 (-7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU rs=100, rt=7 → LO=0x0000000E, HI=0x00000002. Then DIV rs=0x80000000, rt=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU rs=0x1234, rt=0 → done and div_by_zero at T0+2; LO=0xFFFFFFFF, HI=0x00001234.
- MTHI rs=0xAAAA5555, then MTLO rs=0x0F0F0F0F → hi/lo update on the next edges, busy/done never high. Then MULTU 2*3 with start re-pulsed during RUN using rt=9 → HI=0, LO=6, single done.
- MULTU started, reset asserted at T0+10 asynchronously → busy, done, hi, lo all 0 immediately. After release, MULTU 4*4 → LO=16 at T0'+34.
